// File: rtl/mseq_gen.sv
// Chip-rate m-sequence generator: Fibonacci LFSR stepped every DIV clocks,
// with frame counting, byte assembly of the chip stream and phase reload.
module mseq_gen #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
  parameter logic [WIDTH-1:0] SEED     = 4'b0101,
  parameter int              DIV       = 4,
  parameter int              FRAME_LEN = 32
) (
  input  logic             CLK_50MHZ,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             out_fun,
  output logic             sclk,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             frame_sync,
  output logic [15:0]      chip_cnt
);

  localparam logic [7:0]  DIV_LAST  = 8'(DIV - 1);
  localparam logic [15:0] CHIP_LAST = 16'(FRAME_LEN - 1);

  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] phase_reg;
  logic [WIDTH-1:0] load_val;
  logic [7:0]       div_cnt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_next;
  logic [2:0]       bit_cnt;
  logic             fb;
  logic             tick;

  assign fb         = ^(lfsr & TAPS);
  assign tick       = sclk & en;
  assign load_val   = (seed_in == '0) ? SEED : seed_in;
  assign shreg_next = {shreg[6:0], lfsr[WIDTH-1]};
  assign out_fun    = lfsr[WIDTH-1];

  // Load beats any tick in the same cycle; the all-zero guard is applied last
  // so a stuck register is recovered no matter which branch ran.
  always_ff @(posedge CLK_50MHZ) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      phase_reg  <= SEED;
      div_cnt    <= '0;
      chip_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= '0;
      sclk       <= 1'b0;
      data_valid <= 1'b0;
      frame_sync <= 1'b0;
    end else begin
      sclk       <= 1'b0;
      data_valid <= 1'b0;
      frame_sync <= 1'b0;
      if (load) begin
        phase_reg <= load_val;
        lfsr      <= load_val;
        chip_cnt  <= '0;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        shreg     <= '0;
      end else begin
        if (en) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        if (tick) begin
          if (chip_cnt == CHIP_LAST) begin
            lfsr       <= phase_reg;
            chip_cnt   <= '0;
            frame_sync <= 1'b1;
          end else begin
            lfsr     <= {lfsr[WIDTH-2:0], fb};
            chip_cnt <= chip_cnt + 16'd1;
          end
          shreg   <= shreg_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data       <= shreg_next;
            data_valid <= 1'b1;
          end
        end
        if (lfsr == '0) begin
          lfsr <= phase_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_mseq_gen.sv
// Scoreboard bench for mseq_gen: a default instance (a) and a FRAME_LEN=5
// instance (b); expectations are queued ahead and popped by a monitor.
module tb_mseq_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n_a, en_a, load_a, rst_n_b, en_b, load_b;
  logic [3:0] seed_a, seed_b;
  logic       out_a, sclk_a, dv_a, fs_a, out_b, sclk_b, dv_b, fs_b;
  logic [7:0] data_a, data_b;
  logic [15:0] chip_a, chip_b;

  mseq_gen u_dut_a (
    .CLK_50MHZ(clk), .rst_n(rst_n_a), .en(en_a), .load(load_a), .seed_in(seed_a),
    .out_fun(out_a), .sclk(sclk_a), .data(data_a), .data_valid(dv_a),
    .frame_sync(fs_a), .chip_cnt(chip_a)
  );

  mseq_gen #(.FRAME_LEN(5)) u_dut_b (
    .CLK_50MHZ(clk), .rst_n(rst_n_b), .en(en_b), .load(load_b), .seed_in(seed_b),
    .out_fun(out_b), .sclk(sclk_b), .data(data_b), .data_valid(dv_b),
    .frame_sync(fs_b), .chip_cnt(chip_b)
  );

  // Hand-derived state sequence for taps 1100 starting at 0101.
  localparam logic [3:0] SEQ [15] = '{4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8,
                                      4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};

  int checks = 0;
  int errors = 0;

  logic [16:0] qa_tick[$], qb_tick[$];
  logic [7:0]  qa_byte[$], qb_byte[$];
  logic        qb_fs[$];
  logic [16:0] ea, eb;
  logic [7:0]  ba, bb;
  logic        fb_exp;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit which, input logic rst_n, input logic en,
                               input logic load, input logic [3:0] seed);
    if (which) begin
      rst_n_b = rst_n; en_b = en; load_b = load; seed_b = seed;
    end else begin
      rst_n_a = rst_n; en_a = en; load_a = load; seed_a = seed;
    end
  endtask

  task automatic pushTicks(input bit which, input int start_idx, input int start_chip,
                           input int n, input int frame);
    logic [3:0]  s;
    logic [16:0] rec;
    for (int i = 0; i < n; i++) begin
      s   = SEQ[(start_idx + (i % frame)) % 15];
      rec = {16'((start_chip + i) % frame), s[3]};
      if (which) qb_tick.push_back(rec);
      else       qa_tick.push_back(rec);
    end
  endtask

  task automatic waitTick(input bit which, output int gap);
    gap = 0;
    forever begin
      @(negedge clk);
      gap++;
      if ((which ? sclk_b : sclk_a) === 1'b1) return;
      if (gap >= 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL tick_timeout dut %0d got none exp sclk within 40 cycles", which);
        return;
      end
    end
  endtask

  task automatic waitTicks(input bit which, input int n, input int first_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      waitTick(which, gap);
      checkOutput(which ? "b_tick_gap" : "a_tick_gap", gap, (i == 0) ? first_gap : 4);
    end
  endtask

  task automatic checkResetA();
    checkOutput("a_rst_out_fun", out_a, 1'b0);
    checkOutput("a_rst_sclk", sclk_a, 1'b0);
    checkOutput("a_rst_data", data_a, 8'h00);
    checkOutput("a_rst_dv", dv_a, 1'b0);
    checkOutput("a_rst_fs", fs_a, 1'b0);
    checkOutput("a_rst_chip", chip_a, 16'd0);
  endtask

  task automatic runFreeA();
    pushTicks(1'b0, 0, 0, 20, 32);
    qa_byte.push_back(8'h5E);
    qa_byte.push_back(8'h26);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    waitTicks(1'b0, 20, 4);
  endtask

  // Monitor: every presented tick, byte or frame pulse must match the queue head.
  always @(negedge clk) begin
    if (sclk_a === 1'b1) begin
      if (qa_tick.size() == 0) checkOutput("a_unexpected_tick", sclk_a, 1'b0);
      else begin
        ea = qa_tick.pop_front();
        checkOutput("a_tick_chip", chip_a, ea[16:1]);
        checkOutput("a_tick_out", out_a, ea[0]);
      end
    end
    if (dv_a === 1'b1) begin
      if (qa_byte.size() == 0) checkOutput("a_unexpected_dv", dv_a, 1'b0);
      else begin
        ba = qa_byte.pop_front();
        checkOutput("a_byte", data_a, ba);
      end
    end
    if (fs_a === 1'b1) checkOutput("a_unexpected_fs", fs_a, 1'b0);
    if (sclk_b === 1'b1) begin
      if (qb_tick.size() == 0) checkOutput("b_unexpected_tick", sclk_b, 1'b0);
      else begin
        eb = qb_tick.pop_front();
        checkOutput("b_tick_chip", chip_b, eb[16:1]);
        checkOutput("b_tick_out", out_b, eb[0]);
      end
    end
    if (dv_b === 1'b1) begin
      if (qb_byte.size() == 0) checkOutput("b_unexpected_dv", dv_b, 1'b0);
      else begin
        bb = qb_byte.pop_front();
        checkOutput("b_byte", data_b, bb);
      end
    end
    if (fs_b === 1'b1) begin
      if (qb_fs.size() == 0) checkOutput("b_unexpected_fs", fs_b, 1'b0);
      else begin
        fb_exp = qb_fs.pop_front();
        checkOutput("b_fs_chip", chip_b, 16'd0);
        checkOutput("b_fs_out", out_b, fb_exp);
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    checkResetA();

    $display("[TB] free run with defaults");
    runFreeA();
    @(negedge clk);

    $display("[TB] enable low for 10 cycles");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    repeat (10) @(negedge clk);
    checkOutput("a_freeze_chip", chip_a, 16'd20);
    checkOutput("a_freeze_out", out_a, SEQ[5][3]);
    checkOutput("a_freeze_data", data_a, 8'h26);
    pushTicks(1'b0, 5, 20, 3, 32);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    waitTicks(1'b0, 3, 3);
    @(negedge clk);

    $display("[TB] reset mid-frame then replay");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    checkResetA();
    runFreeA();

    $display("[TB] load 1001 coincident with a tick");
    pushTicks(1'b0, 5, 20, 1, 32);
    waitTicks(1'b0, 1, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("a_load_out", out_a, 1'b1);
    checkOutput("a_load_chip", chip_a, 16'd0);
    checkOutput("a_load_data_hold", data_a, 8'h26);
    checkOutput("a_load_sclk", sclk_a, 1'b0);
    pushTicks(1'b0, 10, 0, 8, 32);
    qa_byte.push_back(8'h9A);
    waitTicks(1'b0, 8, 4);
    repeat (2) @(negedge clk);

    $display("[TB] load zero seed");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("a_load0_out", out_a, 1'b0);
    checkOutput("a_load0_chip", chip_a, 16'd0);
    checkOutput("a_load0_data_hold", data_a, 8'h9A);
    pushTicks(1'b0, 0, 0, 8, 32);
    qa_byte.push_back(8'h5E);
    waitTicks(1'b0, 8, 4);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    $display("[TB] frame wrap with FRAME_LEN=5");
    pushTicks(1'b1, 0, 0, 12, 5);
    qb_byte.push_back(8'h5A);
    qb_fs.push_back(1'b0);
    qb_fs.push_back(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    waitTicks(1'b1, 12, 4);
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1001);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    pushTicks(1'b1, 10, 0, 6, 5);
    qb_fs.push_back(1'b1);
    waitTicks(1'b1, 6, 4);
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    pushTicks(1'b1, 0, 0, 6, 5);
    qb_fs.push_back(1'b0);
    waitTicks(1'b1, 6, 4);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);

    checkOutput("a_ticks_left", qa_tick.size(), 0);
    checkOutput("a_bytes_left", qa_byte.size(), 0);
    checkOutput("b_ticks_left", qb_tick.size(), 0);
    checkOutput("b_bytes_left", qb_byte.size(), 0);
    checkOutput("b_fs_left", qb_fs.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mseq_gen.md
MSEQ_GEN -- requirements
Module: mseq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4: LFSR degree, legal 2..16.
REQ-002 SHALL have parameter TAPS, default 4'b1100, WIDTH bits: feedback mask; bit i set puts stage i in the XOR.
REQ-003 SHALL have parameter SEED, default 4'b0101, WIDTH bits: power-on start phase; must be non-zero.
REQ-004 SHALL have parameter DIV, default 4: system clocks per chip, legal 2..255.
REQ-005 SHALL have parameter FRAME_LEN, default 32: chips per frame, legal 1..65535.
REQ-006 SHALL have port CLK_50MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port en, input, 1 bit: run enable.
REQ-009 SHALL have port load, input, 1 bit: one-cycle request to load a new phase.
REQ-010 SHALL have port seed_in, input, WIDTH bits: phase loaded when load=1.
REQ-011 SHALL have port out_fun, output, 1 bit: current chip, equal to lfsr[WIDTH-1].
REQ-012 SHALL have port sclk, output, 1 bit: registered chip strobe, high 1 cycle per chip.
REQ-013 SHALL have port data, output, 8 bits: last 8 chips, first chip in bit 7.
REQ-014 SHALL have port data_valid, output, 1 bit: 1-cycle pulse when data updates.
REQ-015 SHALL have port frame_sync, output, 1 bit: 1-cycle pulse on frame wrap.
REQ-016 SHALL have port chip_cnt, output, 16 bits: chip index within the frame, 0..FRAME_LEN-1.

Function
REQ-017 SHALL keep an 8-bit divider div_cnt; when en=1 and load=0, it counts 0..DIV-1 and wraps; sclk is registered high in the cycle after div_cnt==DIV-1. The first sclk is at cycle DIV after reset release.
REQ-018 SHALL define a tick as a cycle with sclk=1; state advances only on the clock edge that ends a tick cycle.
REQ-019 SHALL, on a tick with chip_cnt != FRAME_LEN-1, shift lfsr <= {lfsr[WIDTH-2:0], fb}, with fb = XOR of lfsr[i] over TAPS[i]=1, and increment chip_cnt.
REQ-020 SHALL, on a tick with chip_cnt == FRAME_LEN-1, reload lfsr from phase_reg instead of shifting, clear chip_cnt, and register frame_sync=1 for exactly one cycle.
REQ-021 SHALL, on every tick, shift the pre-update out_fun into an 8-bit shift register and increment a 3-bit bit counter. When that counter wraps 7->0, data is copied from the shift register including the new bit, and data_valid pulses for one cycle.
REQ-022 SHALL keep the byte counter free-running across frame wraps; only reset and load clear it.
REQ-023 SHALL, on load=1, take priority over any tick in the same cycle:
- phase_reg and lfsr <= seed_in, or SEED if seed_in is all-zero;
- chip_cnt, div_cnt, bit counter and shift register cleared;
- no sclk, frame_sync or data_valid generated from that cycle;
- data holds its value.
REQ-024 SHALL, when en=0, freeze div_cnt, lfsr, counters and data; sclk, frame_sync and data_valid stay 0. load is still honoured.
REQ-025 SHALL force lfsr to phase_reg if it is ever observed all-zero (lock-up guard); no shift from zero is allowed.

Reset
REQ-026 SHALL, when rst_n=0 at an edge, set:
- lfsr=SEED, phase_reg=SEED;
- div_cnt=0, chip_cnt=0, bit counter=0, shift register=0;
- data=8'h00, sclk=0, data_valid=0, frame_sync=0.
Reset overrides load and en; out_fun then equals SEED[WIDTH-1].

Verification
REQ-027 SHALL cover free-run with defaults, en=1 -> ticks at cycles 4,8,...; lfsr follows 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001 ... with period 15.
REQ-028 SHALL cover byte assembly with defaults -> first data_valid after tick 8 with data=8'h5E; second after tick 16 with data=8'h26.
REQ-029 SHALL cover frame wrap with FRAME_LEN=5 -> 5th tick restores lfsr=0101, chip_cnt=0, one frame_sync pulse; pattern repeats every 5 ticks.
REQ-030 SHALL cover load of seed_in=4'b1001 coincident with a tick -> lfsr=1001 and all counters 0; no frame_sync or data_valid; next sclk DIV cycles later.
REQ-031 SHALL cover load of seed_in=0 -> phase_reg=lfsr=0101.
REQ-032 SHALL cover en=0 for 10 cycles mid-run, then rst_n=0 mid-frame -> state frozen during en=0; after reset, outputs match REQ-026 and REQ-027 replays exactly.
